// File: rtl/saes_pkg.sv
// saes_pkg: S-AES constants, state/stage enums and GF(2^4) helpers shared by the sequencer and round unit.
package saes_pkg;
  localparam logic [3:0] SBOX [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                       4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
  localparam logic [3:0] INV_SBOX [16] = '{4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
                                           4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE};
  localparam logic [7:0] RCON1 = 8'h80;
  localparam logic [7:0] RCON2 = 8'h30;
  typedef enum logic [2:0] {IDLE, EXP1, EXP2, RND0, RND1, RND2, DONE} state_t;
  typedef enum logic [1:0] {ADDKEY, FULL, FINAL} stage_t;
  // shift-and-add multiply, reducing x^4 back to x+1
  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction
  function automatic logic [15:0] mix_cols(input logic [15:0] w, input logic [3:0] a, input logic [3:0] b);
    return {gf4_mul(a, w[15:12]) ^ gf4_mul(b, w[11:8]), gf4_mul(b, w[15:12]) ^ gf4_mul(a, w[11:8]),
            gf4_mul(a, w[7:4]) ^ gf4_mul(b, w[3:0]), gf4_mul(b, w[7:4]) ^ gf4_mul(a, w[3:0])};
  endfunction
  function automatic logic [15:0] expand_key(input logic [15:0] k, input logic [7:0] rcon);
    logic [7:0] w;
    w = k[15:8] ^ {SBOX[k[3:0]], SBOX[k[7:4]]} ^ rcon;
    return {w, w ^ k[7:0]};
  endfunction
endpackage

// File: rtl/saes_round_unit.sv
// saes_round_unit: combinational S-AES round stage (add-key, full or final round) for either direction.
module saes_round_unit
  import saes_pkg::*;
(
  input  logic [15:0] st,
  input  logic [15:0] rk,
  input  logic        dec,
  input  stage_t      stage,
  output logic [15:0] nxt
);
  logic [15:0] sub, sr, ak;
  // nibble substitution commutes with ShiftRow, so both directions share one sub/shift path
  for (genvar n = 0; n < 4; n++) begin : g_sub
    assign sub[n*4 +: 4] = dec ? INV_SBOX[st[n*4 +: 4]] : SBOX[st[n*4 +: 4]];
  end
  assign sr  = {sub[15:12], sub[3:0], sub[7:4], sub[11:8]};
  assign ak  = sr ^ rk;
  assign nxt = stage == ADDKEY ? st ^ rk :
               stage == FINAL  ? ak :
               dec             ? mix_cols(ak, 4'h9, 4'h2) : mix_cols(sr, 4'h1, 4'h4) ^ rk;
endmodule

// File: rtl/saes_round_sequencer.sv
// saes_round_sequencer: iterative S-AES encrypt/decrypt controller with valid/ready handshake and optional key cache.
module saes_round_sequencer
  import saes_pkg::*;
#(
  parameter bit KEY_CACHE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [15:0] in_key,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);
  state_t      state, state_nx;
  stage_t      stage;
  logic        dec, key_vld, accept, hit;
  logic [15:0] dat, k0, k1, k2, rk, nxt;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign accept    = in_valid && in_ready;
  assign hit       = KEY_CACHE && key_vld && in_key == k0;
  assign stage     = state == RND0 ? ADDKEY : state == RND1 ? FULL : FINAL;
  // encrypt whitens with k0 and finishes with k2; decrypt runs the schedule backwards
  assign rk        = state == RND1 ? k1 : ((state == RND0) ^ dec) ? k0 : k2;
  saes_round_unit u_round (
    .st    (dat),
    .rk    (rk),
    .dec   (dec),
    .stage (stage),
    .nxt   (nxt)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = hit ? RND0 : EXP1;
      EXP1:    state_nx = EXP2;
      EXP2:    state_nx = RND0;
      RND0:    state_nx = RND1;
      RND1:    state_nx = RND2;
      RND2:    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dec      <= 1'b0;
      dat      <= '0;
      k0       <= '0;
      k1       <= '0;
      k2       <= '0;
      key_vld  <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        dec <= in_mode;
        dat <= in_data;
        k0  <= in_key;
        if (!hit) key_vld <= 1'b0;
      end
      if (state == EXP1) k1 <= expand_key(k0, RCON1);
      if (state == EXP2) begin
        k2      <= expand_key(k1, RCON2);
        key_vld <= 1'b1;
      end
      if (state inside {RND0, RND1, RND2}) dat <= nxt;
      if (state == RND2) out_data <= nxt;
    end
  end
endmodule

// File: tb/tb_saes_round_sequencer.sv
// tb_saes_round_sequencer: randomized self-checking bench against a step-by-step S-AES reference model.
module tb_saes_round_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic [15:0] in_key = '0, in_data = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_data;
  logic        nc_valid = 1'b0, nc_out_ready = 1'b1;
  logic        nc_in_ready, nc_out_valid, nc_busy;
  logic [15:0] nc_out_data;
  int          checks = 0, errors = 0;
  bit          kv = 1'b0;
  logic [15:0] last_key = '0;

  always #5 clk = ~clk;

  saes_round_sequencer #(.KEY_CACHE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_key(in_key), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy));

  saes_round_sequencer #(.KEY_CACHE(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid(nc_valid), .in_ready(nc_in_ready), .in_mode(in_mode),
    .in_key(in_key), .in_data(in_data), .out_valid(nc_out_valid), .out_ready(nc_out_ready),
    .out_data(nc_out_data), .busy(nc_busy));

  function automatic logic [3:0] sb(input logic [3:0] n, input bit inv);
    logic [63:0] t;
    t = inv ? 64'hA59B178F6023C4DE : 64'h94ABD1856203CEF7;
    return t[63 - 4*int'(n) -: 4];
  endfunction

  // carry-less product then polynomial long division by x^4+x+1
  function automatic logic [3:0] gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) if ((b >> i) & 1) p ^= a << i;
    for (int i = 6; i >= 4; i--) if ((p >> i) & 1) p ^= 'h13 << (i - 4);
    return 4'(p);
  endfunction

  function automatic logic [15:0] sub_w(input logic [15:0] s, input bit inv);
    return {sb(s[15:12], inv), sb(s[11:8], inv), sb(s[7:4], inv), sb(s[3:0], inv)};
  endfunction

  function automatic logic [15:0] shr(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  function automatic logic [15:0] mixc(input logic [15:0] s, input int a, input int b);
    return {gmul(a, int'(s[15:12])) ^ gmul(b, int'(s[11:8])), gmul(b, int'(s[15:12])) ^ gmul(a, int'(s[11:8])),
            gmul(a, int'(s[7:4])) ^ gmul(b, int'(s[3:0])), gmul(b, int'(s[7:4])) ^ gmul(a, int'(s[3:0]))};
  endfunction

  function automatic logic [15:0] ref_saes(input bit dec, input logic [15:0] key, input logic [15:0] din);
    logic [7:0]  w [6];
    logic [15:0] k [3];
    logic [15:0] s;
    w[0] = key[15:8];
    w[1] = key[7:0];
    for (int r = 1; r < 3; r++) begin
      w[2*r]   = w[2*r-2] ^ (r == 1 ? 8'h80 : 8'h30) ^ {sb(w[2*r-1][3:0], 1'b0), sb(w[2*r-1][7:4], 1'b0)};
      w[2*r+1] = w[2*r] ^ w[2*r-1];
    end
    for (int r = 0; r < 3; r++) k[r] = {w[2*r], w[2*r+1]};
    if (!dec) begin
      s = din ^ k[0];
      s = mixc(shr(sub_w(s, 1'b0)), 1, 4) ^ k[1];
      s = shr(sub_w(s, 1'b0)) ^ k[2];
    end else begin
      s = din ^ k[2];
      s = mixc(sub_w(shr(s), 1'b1) ^ k[1], 9, 2);
      s = sub_w(shr(s), 1'b1) ^ k[0];
    end
    return s;
  endfunction

  // one request on the cached DUT; waits for result and completes handshake if out_ready is high
  task automatic run_req(input bit m, input logic [15:0] k, input logic [15:0] d, input bit scramble);
    int lat, exp_lat;
    logic [15:0] exp_d;
    exp_d   = ref_saes(m, k, d);
    exp_lat = (kv && k == last_key) ? 3 : 5;
    lat = 0;
    while (!in_ready && lat < 20) begin @(posedge clk); #1; lat++; end
    in_mode = m; in_key = k; in_data = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    kv = 1'b1;
    last_key = k;
    lat = 0;
    while (!out_valid && lat < 20) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_busy got %b want 0", in_ready); end
      if (scramble) begin
        in_mode = 1'($urandom); in_key = 16'($urandom); in_data = 16'($urandom); in_valid = 1'($urandom);
      end
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL latency key=%h got %0d want %0d", k, lat, exp_lat); end
    checks++;
    if (out_data !== exp_d) begin errors++; $display("FAIL result m=%0d k=%h d=%h got %h want %h", m, k, d, out_data, exp_d); end
    if (out_ready) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL handshake out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset;
    #12;
    checks += 4;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    logic [47:0] v [4];
    v[0] = {1'b0, 15'h0, 16'h4AF5, 16'hD728};
    v[1] = {1'b1, 15'h0, 16'h4AF5, 16'h24EC};
    v[2] = {1'b1, 15'h0, 16'hA73B, 16'h0738};
    v[3] = {1'b0, 15'h0, 16'hA73B, 16'h6F6B};
    for (int i = 0; i < 4; i++) begin
      logic [15:0] want;
      want = i == 0 ? 16'h24EC : i == 1 ? 16'hD728 : i == 2 ? 16'h6F6B : 16'h0738;
      run_req(v[i][47], v[i][31:16], v[i][15:0], 1'b0);
      checks++;
      if (out_data !== want) begin errors++; $display("FAIL vector%0d got %h want %h", i, out_data, want); end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    run_req(1'b0, 16'h4AF5, 16'hD728, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom); in_key = 16'($urandom); in_mode = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h24EC || in_ready !== 1'b0) begin
        errors++; $display("FAIL backpressure cyc%0d valid=%b data=%h ready=%b want 1/24EC/0", i, out_valid, out_data, in_ready);
      end
    end
    in_mode = 1'b1; in_key = 16'hA73B; in_data = 16'h0738;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept busy=%b want 1", busy); end
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (out_data !== 16'h6F6B) begin errors++; $display("FAIL bp_next_result got %h want 6F6B", out_data); end
    last_key = 16'hA73B;
    @(posedge clk); #1;
  endtask

  task automatic test_cache;
    run_req(1'b0, 16'h4AF5, 16'($urandom), 1'b0);
    run_req(1'b1, 16'h4AF5, 16'($urandom), 1'b0);
    run_req(1'b0, 16'hA73B, 16'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid;
    in_mode = 1'b0; in_key = 16'h1234; in_data = 16'hBEEF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    kv = 1'b0;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready got %b want 1", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy); end
    if (out_data !== 16'h0000) begin errors++; $display("FAIL mid_reset_out_data got %h want 0000", out_data); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_req(1'b1, 16'h1234, 16'hBEEF, 1'b0);
  endtask

  task automatic test_random;
    logic [15:0] pool [3];
    pool[0] = 16'h4AF5;
    pool[1] = 16'hA73B;
    for (int i = 0; i < 20; i++) begin
      pool[2] = 16'($urandom);
      run_req(1'($urandom), pool[$urandom_range(0, 2)], 16'($urandom), 1'b1);
    end
  endtask

  task automatic test_no_cache;
    int lat;
    logic [15:0] exp_d;
    for (int j = 0; j < 2; j++) begin
      in_mode = 1'(j); in_key = 16'h4AF5; in_data = 16'($urandom);
      exp_d = ref_saes(in_mode, in_key, in_data);
      nc_valid = 1'b1;
      @(posedge clk); #1;
      nc_valid = 1'b0;
      lat = 0;
      while (!nc_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      checks += 2;
      if (lat !== 5) begin errors++; $display("FAIL nocache_latency%0d got %0d want 5", j, lat); end
      if (nc_out_data !== exp_d) begin errors++; $display("FAIL nocache_result%0d got %h want %h", j, nc_out_data, exp_d); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_backpressure;
    test_cache;
    test_reset_mid;
    test_random;
    test_no_cache;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
